// File: rtl/rom_loader.sv
// rom_loader
//   Streams a program image from a host byte interface into the flat rom
//   bus that feeds the cpu. It holds the cpu in reset while loading, then
//   releases it and watches the cpu's scratch memory for an "=good" or
//   "=bad" verdict string. It reports pass, fail or timeout together with
//   the number of run cycles.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   restart            synchronous pulse: abort and reload from byte 0
//   in_valid/in_data   host byte stream
//   in_ready           byte accepted this cycle (LOAD only)
//   rom                program image, byte k at rom[8k +: 8]
//   cpu_rst            registered reset to the cpu
//   memory_out         cpu memory[8..31], byte j at [8j +: 8]
//   done/pass/fail/timeout, run_cycles   latched verdict
module rom_loader #(
   parameter int ROM_BYTES      = 82,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   restart,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic [8*ROM_BYTES-1:0] rom,
   output logic                   cpu_rst,
   input  logic [8*24-1:0]        memory_out,
   output logic                   done,
   output logic                   pass,
   output logic                   fail,
   output logic                   timeout,
   output logic [15:0]            run_cycles
);

   localparam int                CNT_W    = $clog2(ROM_BYTES + 1);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(ROM_BYTES - 1);
   localparam logic [15:0]       TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [8*ROM_BYTES-1:0] rom_q, rom_d;
   logic                   cpu_rst_q, cpu_rst_d;
   logic [15:0]            cyc_q, cyc_d;
   logic                   done_q, done_d;
   logic                   pass_q, pass_d;
   logic                   fail_q, fail_d;
   logic                   timeout_q, timeout_d;
   logic [15:0]            run_cycles_q, run_cycles_d;
   logic                   good_match;
   logic                   bad_match;

   // "=good\0" and "=bad\0" in cpu memory starting at address 8
   assign good_match = (memory_out[7:0]   == 8'h3D) && (memory_out[15:8]  == 8'h67) &&
                       (memory_out[23:16] == 8'h6F) && (memory_out[31:24] == 8'h6F) &&
                       (memory_out[39:32] == 8'h64) && (memory_out[47:40] == 8'h00);
   assign bad_match  = (memory_out[7:0]   == 8'h3D) && (memory_out[15:8]  == 8'h62) &&
                       (memory_out[23:16] == 8'h61) && (memory_out[31:24] == 8'h64) &&
                       (memory_out[39:32] == 8'h00);

   assign in_ready = (state_q == S_LOAD) & ~rst;

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      rom_d        = rom_q;
      cpu_rst_d    = cpu_rst_q;
      cyc_d        = cyc_q;
      done_d       = done_q;
      pass_d       = pass_q;
      fail_d       = fail_q;
      timeout_d    = timeout_q;
      run_cycles_d = run_cycles_q;

      case (state_q)
         S_LOAD: begin
            cpu_rst_d = 1'b1;
            if (in_valid && in_ready) begin
               rom_d[{count_q, 3'b000} +: 8] = in_data;
               count_d = count_q + 1'b1;
               if (count_q == LAST_IDX) state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            // cpu has seen reset for one cycle with the final image stable
            state_d   = S_RUN;
            cpu_rst_d = 1'b0;
            cyc_d     = '0;
         end
         S_RUN: begin
            cpu_rst_d = 1'b0;
            if (good_match || bad_match) begin
               state_d      = S_DONE;
               done_d       = 1'b1;
               pass_d       = good_match;
               fail_d       = ~good_match;
               run_cycles_d = cyc_q;
               cpu_rst_d    = 1'b1;
            end else if (cyc_q == TO_LAST) begin
               state_d      = S_DONE;
               done_d       = 1'b1;
               timeout_d    = 1'b1;
               run_cycles_d = cyc_q;
               cpu_rst_d    = 1'b1;
            end else if (cyc_q != 16'hFFFF) begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         default: begin
            // verdict held, cpu frozen
            cpu_rst_d = 1'b1;
         end
      endcase

      // restart overrides everything, including a same-cycle handshake
      if (restart) begin
         state_d      = S_LOAD;
         count_d      = '0;
         rom_d        = '0;
         cpu_rst_d    = 1'b1;
         cyc_d        = '0;
         done_d       = 1'b0;
         pass_d       = 1'b0;
         fail_d       = 1'b0;
         timeout_d    = 1'b0;
         run_cycles_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_LOAD;
         count_q      <= '0;
         rom_q        <= '0;
         cpu_rst_q    <= 1'b1;
         cyc_q        <= '0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         timeout_q    <= 1'b0;
         run_cycles_q <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         rom_q        <= rom_d;
         cpu_rst_q    <= cpu_rst_d;
         cyc_q        <= cyc_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         timeout_q    <= timeout_d;
         run_cycles_q <= run_cycles_d;
      end
   end

   assign rom        = rom_q;
   assign cpu_rst    = cpu_rst_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign timeout    = timeout_q;
   assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

   localparam int NB = 82;

   logic            clk = 1'b0;
   logic            rst;
   logic            restart;
   logic            in_valid;
   logic [7:0]      in_data;
   logic            in_ready;
   logic [8*NB-1:0] rom;
   logic            cpu_rst;
   logic [191:0]    mo;
   logic            done, pass, fail, timeout;
   logic [15:0]     run_cycles;

   int total = 0;
   int bad   = 0;

   rom_loader #(.ROM_BYTES(NB), .TIMEOUT_CYCLES(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .restart    (restart),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .rom        (rom),
      .cpu_rst    (cpu_rst),
      .memory_out (mo),
      .done       (done),
      .pass       (pass),
      .fail       (fail),
      .timeout    (timeout),
      .run_cycles (run_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_bytes(input logic [8*NB-1:0] img);
      for (int i = 0; i < NB; i++) begin
         in_valid = 1'b1;
         in_data  = img[8*i +: 8];
         tick();
      end
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic do_restart();
      restart = 1'b1;
      tick();
      restart = 1'b0;
   endtask

   function automatic logic [191:0] good_str();
      logic [191:0] m = '0;
      m[7:0] = 8'h3D; m[15:8] = 8'h67; m[23:16] = 8'h6F; m[31:24] = 8'h6F; m[39:32] = 8'h64;
      return m;
   endfunction

   function automatic logic [191:0] bad_str(input logic [7:0] b4);
      logic [191:0] m = '0;
      m[7:0] = 8'h3D; m[15:8] = 8'h62; m[23:16] = 8'h61; m[31:24] = 8'h64; m[39:32] = b4;
      return m;
   endfunction

   initial begin
      logic [8*NB-1:0] img;
      logic            v;
      int              hs;

      rst = 1'b1; restart = 1'b0; in_valid = 1'b0; in_data = 8'h00; mo = '0;

      // reset state
      #12;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_cpu_rst", cpu_rst, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_rom", rom, '0);
      chk("rst_run_cycles", run_cycles, 16'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("post_rst_ready", in_ready, 1'b1);

      // good verdict
      img = '0; img[7:0] = 8'hD0;
      load_bytes(img);
      chk("a_release_ready", in_ready, 1'b0);
      chk("a_release_cpu_rst", cpu_rst, 1'b1);
      chk("a_rom", rom, img);
      chk("a_rom_byte0", rom[7:0], 8'hD0);
      tick();
      chk("a_run_cpu_rst", cpu_rst, 1'b0);
      tick(); tick();
      mo = good_str();
      chk("a_pre_done", done, 1'b0);
      tick();
      chk("a_done", done, 1'b1);
      chk("a_pass", pass, 1'b1);
      chk("a_fail", fail, 1'b0);
      chk("a_timeout", timeout, 1'b0);
      chk("a_run_cycles", run_cycles, 16'd2);
      chk("a_freeze_cpu", cpu_rst, 1'b1);
      mo = '0;
      tick(); tick(); tick();
      chk("a_hold_pass", {done, pass}, 2'b11);
      do_restart();
      chk("rs_rom", rom, '0);
      chk("rs_flags", {done, pass, fail, timeout}, 4'b0000);
      chk("rs_run_cycles", run_cycles, 16'd0);
      chk("rs_ready", in_ready, 1'b1);
      chk("rs_cpu_rst", cpu_rst, 1'b1);

      // bad verdict, with a near-miss string first
      img = '0; img[7:0] = 8'hD8;
      load_bytes(img);
      tick();
      mo = bad_str(8'h21);
      tick();
      chk("b_near_miss", done, 1'b0);
      mo = bad_str(8'h00);
      tick();
      chk("b_done", done, 1'b1);
      chk("b_fail", fail, 1'b1);
      chk("b_pass", pass, 1'b0);
      chk("b_timeout", timeout, 1'b0);
      chk("b_run_cycles", run_cycles, 16'd1);
      // asynchronous reset while the verdict is held
      #2 rst = 1'b1;
      #1;
      chk("b_arst_done", done, 1'b0);
      chk("b_arst_fail", fail, 1'b0);
      chk("b_arst_cpu_rst", cpu_rst, 1'b1);
      chk("b_arst_ready", in_ready, 1'b0);
      chk("b_arst_rom", rom, '0);
      rst = 1'b0; mo = '0;
      #1;
      chk("b_arst_ready_after", in_ready, 1'b1);

      // timeout after exactly 64 run cycles
      load_bytes('0);
      tick();
      repeat (63) tick();
      chk("c_not_yet", done, 1'b0);
      chk("c_cpu_running", cpu_rst, 1'b0);
      tick();
      chk("c_done", done, 1'b1);
      chk("c_timeout", timeout, 1'b1);
      chk("c_pass_fail", {pass, fail}, 2'b00);
      chk("c_run_cycles", run_cycles, 16'd63);
      do_restart();

      // verdict on the timeout edge wins
      load_bytes('0);
      tick();
      repeat (63) tick();
      mo = good_str();
      tick();
      chk("d_pass", {done, pass, fail, timeout}, 4'b1100);
      chk("d_run_cycles", run_cycles, 16'd63);
      mo = '0;
      do_restart();

      // backpressure with gaps, then 3 extra offered bytes
      img = '0; hs = 0; v = 1'b0;
      for (int c = 0; c < 400 && hs < NB; c++) begin
         v        = ~v;
         in_valid = v;
         in_data  = 8'($urandom);
         if (in_valid && in_ready) begin
            img[8*hs +: 8] = in_data;
            hs++;
         end
         tick();
      end
      chk("e_ready_release", in_ready, 1'b0);
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         if (in_ready) hs++;
         tick();
      end
      in_valid = 1'b0;
      chk("e_handshakes", hs, NB);
      chk("e_rom", rom, img);
      do_restart();

      // restart coinciding with byte 41
      for (int i = 0; i < 40; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i + 1);
         tick();
      end
      in_data = 8'hAA; restart = 1'b1;
      tick();
      restart = 1'b0; in_valid = 1'b0;
      chk("f_rom_cleared", rom, '0);
      chk("f_ready", in_ready, 1'b1);
      for (int i = 0; i < NB; i++) img[8*i +: 8] = 8'(8'h80 + i);
      load_bytes(img);
      chk("f_rom", rom, img);
      chk("f_byte0", rom[7:0], 8'h80);

      // asynchronous reset mid-RUN
      tick(); tick();
      chk("g_running", cpu_rst, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("g_arst_cpu_rst", cpu_rst, 1'b1);
      chk("g_arst_done", done, 1'b0);
      chk("g_arst_ready", in_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("g_ready_after", in_ready, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rom_loader.md
# rom_loader

Host-side companion to the `cpu` core: it writes the program image that the CPU reads, then watches the CPU's verdict. Loader streams a program image over a valid/ready byte interface into the flat `rom` bus feeding `cpu`, and holds the CPU in reset while loading. After loading, it releases the CPU, watches `memory_out` for the `=good` / `=bad` verdict strings, and reports pass/fail/timeout with a cycle count.

## Interface
- `ROM_BYTES`, default 82, program image size in bytes; width of `rom` is 8*ROM_BYTES.
- `TIMEOUT_CYCLES`, default 4096, maximum RUN cycles before timeout (>=2).
- `clk`  input  1  single clock, all state on rising edge.
- `rst`  input  1  reset; one clock, reset is asynchronous and active-high.
- `restart`  input  1  synchronous pulse: abort and return to LOAD.
- `in_valid`  input  1  host byte valid.
- `in_data`  input  8  host byte.
- `in_ready`  output  1  loader accepts a byte this cycle.
- `rom`  output  8*ROM_BYTES  program image, byte k at `rom[8k +: 8]`, to `cpu.rom`.
- `cpu_rst`  output  1  registered synchronous reset to `cpu.rst`.
- `memory_out`  input  8*24  from `cpu.memory_out`; byte j (`[8j +: 8]`) is CPU memory[8+j].
- `done`  output  1  verdict latched.
- `pass`  output  1  `=good` seen.
- `fail`  output  1  `=bad` seen.
- `timeout`  output  1  no verdict within TIMEOUT_CYCLES.
- `run_cycles`  output  16  RUN cycles elapsed at verdict, saturating at 0xFFFF.

## Operation
- States: LOAD -> RELEASE -> RUN -> DONE. Any state -> LOAD on `restart`.
- Reset (async, immediate): state=LOAD; `rom` all 0; byte count 0; `cpu_rst`=1; `done`/`pass`/`fail`/`timeout`=0; `run_cycles`=0.
- `in_ready` = (state==LOAD) & ~rst, combinational from state.
- LOAD:
  - A handshake (`in_valid & in_ready`) writes `in_data` to `rom[8*count +: 8]` and increments count.
  - When the accepted byte is index ROM_BYTES-1, go to RELEASE.
  - `cpu_rst` stays 1.
- RELEASE: one cycle, `cpu_rst` still 1 so the CPU samples reset once after the final image is stable. Go to RUN; `cpu_rst` goes to 0 on the same edge.
- RUN: `cpu_rst`=0; the cycle counter increments each edge.
  - Good match: memory_out bytes 0..4 = 0x3D,0x67,0x6F,0x6F,0x64 ("=good") and byte 5 = 0.
  - Bad match: bytes 0..3 = 0x3D,0x62,0x61,0x64 ("=bad") and byte 4 = 0.
  - Either match -> DONE with `pass` or `fail` set; `run_cycles` = counter value at that edge.
  - Counter reaching TIMEOUT_CYCLES-1 without a match -> DONE with `timeout`=1.
- DONE: `done`=1 and flags hold; `cpu_rst` reasserts to 1 to freeze the CPU. Leave only on `restart` or `rst`.
- `restart`: zeroes `rom`, count, counter, flags and `run_cycles`; sets `cpu_rst`=1; state=LOAD.
- Exactly one of `pass`/`fail`/`timeout` is set whenever `done`=1; all are 0 when `done`=0.

## Timing
- Byte accepted at edge E appears on `rom` after E. No extra bytes are accepted once count=ROM_BYTES (`in_ready`=0). `in_valid` gaps are allowed; `in_data` is ignored when not handshaken.
- Last byte at edge T: RELEASE after T, `cpu_rst` falls after T+1, and the first CPU instruction executes at edge T+2.
- The verdict is registered: a match present on `memory_out` during cycle N sets `done` after edge N.
- Priority: `rst` > `restart` > verdict match > timeout > handshake.
  - `restart` together with a handshake: the byte is discarded.
  - A match on the same edge the timeout would fire: the verdict wins, `timeout`=0.
- `rst` mid-RUN: the outputs go to reset values asynchronously, without a clock edge; `cpu_rst`=1 immediately.
- Byte count width is clog2(ROM_BYTES+1); the cycle counter is 16 bits saturating, and the compare is against TIMEOUT_CYCLES-1.

## Test plan
- Load 82 bytes, byte0=0xD0 (GOOD opcode), rest 0x00, connected to `cpu` -> `pass`=1, `done`=1, `fail`=`timeout`=0, `run_cycles`<=3; `rom[7:0]`=0xD0.
- Same with byte0=0xD8 (BAD opcode) -> `fail`=1, `pass`=0, `done`=1.
- All-zero image, TIMEOUT_CYCLES=64 -> `timeout`=1 and `done`=1 exactly 64 RUN cycles after `cpu_rst` falls; `pass`=`fail`=0.
- Backpressure: `in_valid` toggling every other cycle with random `in_data`, then 3 extra bytes after the 82nd -> exactly 82 handshakes, `in_ready`=0 from RELEASE onward, `rom` matches the first 82 bytes.
- `restart` after 40 bytes, simultaneous with byte 41 -> `rom` all 0, byte 41 discarded; the next 82 bytes load from index 0.
- Assert `rst` mid-RUN between clock edges -> `cpu_rst`=1 and `done`=0 before the next edge; `in_ready`=1 once `rst` drops.
